// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_LOW,
    BTN_CHK_HIGH,
    BTN_HIGH,
    BTN_CHK_LOW
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM, registered press/release pulses.
// Auto-repeat while held is built only when BTN_CONDITIONER_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   s;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_run_q, rep_run_d;
`endif

  // Oldest synchroniser stage is the only one the FSM may look at.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    rep_cnt_d = '0;
    rep_run_d = 1'b0;
`endif

    unique case (state_q)
      BTN_LOW: begin
        if (s) begin
          state_d = BTN_CHK_HIGH;
          cnt_d   = '0;
        end
      end
      BTN_CHK_HIGH: begin
        if (!s) begin
          state_d = BTN_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = BTN_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BTN_HIGH: begin
        if (!s) begin
          state_d = BTN_CHK_LOW;
          cnt_d   = '0;
        end else begin
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
          // First repeat waits the long delay, later ones use the short period.
          if (rep_cnt_q == (rep_run_q ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
            press_d   = 1'b1;
            rep_cnt_d = '0;
            rep_run_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
            rep_run_d = rep_run_q;
          end
`endif
        end
      end
      BTN_CHK_LOW: begin
        if (s) begin
          state_d = BTN_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = BTN_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BTN_LOW;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset_i) begin
      sync_q    <= '0;
      state_q   <= BTN_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      rep_cnt_q <= '0;
      rep_run_q <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      rep_cnt_q <= rep_cnt_d;
      rep_run_q <= rep_run_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions NUM_BTN raw board buttons into clean levels and press/release pulses.
// Define BTN_CONDITIONER_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .btn_i    (btn_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat constants.
// Cycle index 1 is the first clock edge that samples a new input value.
module tb_btn_conditioner;

  localparam int NUM_BTN = 3;
  localparam int SYNC    = 2;
  localparam int DEB     = 8;
  localparam int RDELAY  = 20;
  localparam int RPERIOD = 6;
  // Output change lands SYNC+DEB cycles after the sampling edge (index 1).
  localparam int LAT_IDX = 1 + SYNC + DEB;

  logic               clk = 1'b0;
  logic               reset_i;
  logic [NUM_BTN-1:0] btn_i;
  logic [NUM_BTN-1:0] level_o, press_o, release_o;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int pc, p1, p2, p3;
    int rc, r1;
    int both, lvl_hi, other;
    int lvl_before_p, lvl_at_p, lvl_before_r, lvl_at_r;
  } obs_t;

  btn_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPERIOD)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .btn_i    (btn_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o)
  );

  always #5 clk = ~clk;

  // Samples channel ch for n cycles, 1 time unit after each rising edge.
  task automatic watch(input int ch, input int n, output obs_t o);
    int prev_lvl;
    o = '{default: 0};
    o.p1 = -1; o.p2 = -1; o.p3 = -1; o.r1 = -1;
    prev_lvl = int'(level_o[ch]);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (press_o[ch]) begin
        o.pc++;
        if (o.pc == 1) begin
          o.p1 = i; o.lvl_before_p = prev_lvl; o.lvl_at_p = int'(level_o[ch]);
        end
        if (o.pc == 2) o.p2 = i;
        if (o.pc == 3) o.p3 = i;
      end
      if (release_o[ch]) begin
        o.rc++;
        if (o.rc == 1) begin
          o.r1 = i; o.lvl_before_r = prev_lvl; o.lvl_at_r = int'(level_o[ch]);
        end
      end
      if (press_o[ch] && release_o[ch]) o.both++;
      if (level_o[ch]) o.lvl_hi++;
      for (int c = 0; c < NUM_BTN; c++)
        if (c != ch && (press_o[c] || release_o[c])) o.other++;
      prev_lvl = int'(level_o[ch]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    btn_i   = '0;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (level_o !== '0) $display("FAIL reset_level got=%b exp=000", level_o); else n_pass++;
    n_total++; if (press_o !== '0) $display("FAIL reset_press got=%b exp=000", press_o); else n_pass++;
    n_total++; if (release_o !== '0) $display("FAIL reset_release got=%b exp=000", release_o); else n_pass++;
    reset_i = 1'b0;
    repeat (4) @(negedge clk);
    n_total++; if (level_o !== '0) $display("FAIL idle_level got=%b exp=000", level_o); else n_pass++;
  endtask

  task automatic test_press();
    obs_t o;
    @(negedge clk);
    btn_i[0] = 1'b1;
    watch(0, 20, o);
    n_total++; if (o.pc !== 1) $display("FAIL press_count got=%0d exp=1", o.pc); else n_pass++;
    n_total++; if (o.p1 !== LAT_IDX) $display("FAIL press_latency got=%0d exp=%0d", o.p1, LAT_IDX); else n_pass++;
    n_total++; if (o.lvl_before_p !== 0 || o.lvl_at_p !== 1)
      $display("FAIL press_level_edge got=%0d->%0d exp=0->1", o.lvl_before_p, o.lvl_at_p); else n_pass++;
    n_total++; if (o.rc !== 0) $display("FAIL press_no_release got=%0d exp=0", o.rc); else n_pass++;
    n_total++; if (o.other !== 0) $display("FAIL press_cross_channel got=%0d exp=0", o.other); else n_pass++;
  endtask

  task automatic test_release();
    obs_t o;
    @(negedge clk);
    btn_i[0] = 1'b0;
    watch(0, 20, o);
    n_total++; if (o.rc !== 1) $display("FAIL release_count got=%0d exp=1", o.rc); else n_pass++;
    n_total++; if (o.r1 !== LAT_IDX) $display("FAIL release_latency got=%0d exp=%0d", o.r1, LAT_IDX); else n_pass++;
    n_total++; if (o.lvl_before_r !== 1 || o.lvl_at_r !== 0)
      $display("FAIL release_level_edge got=%0d->%0d exp=1->0", o.lvl_before_r, o.lvl_at_r); else n_pass++;
    n_total++; if (o.pc !== 0 || o.both !== 0)
      $display("FAIL release_no_press got=%0d/%0d exp=0/0", o.pc, o.both); else n_pass++;
  endtask

  task automatic test_glitch();
    obs_t o;
    @(negedge clk);
    fork
      begin
        btn_i[1] = 1'b1;
        repeat (5) @(negedge clk);
        btn_i[1] = 1'b0;
      end
      watch(1, 25, o);
    join
    n_total++; if (o.pc !== 0 || o.rc !== 0)
      $display("FAIL glitch_pulses got=%0d/%0d exp=0/0", o.pc, o.rc); else n_pass++;
    n_total++; if (o.lvl_hi !== 0) $display("FAIL glitch_level got=%0d exp=0", o.lvl_hi); else n_pass++;
  endtask

  task automatic test_bounce();
    obs_t o;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          btn_i[0] = (k % 2 == 0);
          repeat (3) @(negedge clk);
        end
        btn_i[0] = 1'b1;
      end
      watch(0, 40, o);
    join
    // Settled value is applied 18 cycles in, so it is sampled at index 19.
    n_total++; if (o.pc !== 1) $display("FAIL bounce_count got=%0d exp=1", o.pc); else n_pass++;
    n_total++; if (o.p1 !== 18 + LAT_IDX) $display("FAIL bounce_latency got=%0d exp=%0d", o.p1, 18 + LAT_IDX); else n_pass++;
    n_total++; if (o.rc !== 0) $display("FAIL bounce_release got=%0d exp=0", o.rc); else n_pass++;
    @(negedge clk);
    btn_i[0] = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    btn_i[0] = 1'b1;
    watch(0, 5, o);
    n_total++; if (o.pc !== 0 || o.lvl_hi !== 0)
      $display("FAIL midrst_pre got=%0d/%0d exp=0/0", o.pc, o.lvl_hi); else n_pass++;
    @(negedge clk);
    reset_i = 1'b1;
    watch(0, 2, o);
    n_total++; if (o.pc !== 0 || o.lvl_hi !== 0)
      $display("FAIL midrst_during got=%0d/%0d exp=0/0", o.pc, o.lvl_hi); else n_pass++;
    @(negedge clk);
    reset_i = 1'b0;
    watch(0, 20, o);
    n_total++; if (o.pc !== 1) $display("FAIL midrst_count got=%0d exp=1", o.pc); else n_pass++;
    n_total++; if (o.p1 !== LAT_IDX) $display("FAIL midrst_latency got=%0d exp=%0d", o.p1, LAT_IDX); else n_pass++;
    @(negedge clk);
    btn_i[0] = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_autorepeat();
    obs_t o;
    @(negedge clk);
    btn_i[2] = 1'b1;
    watch(2, 60, o);
    n_total++; if (o.p1 !== LAT_IDX) $display("FAIL hold_first got=%0d exp=%0d", o.p1, LAT_IDX); else n_pass++;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    // Presses at 11, 31, 37, 43, 49, 55 within the 60-cycle window.
    n_total++; if (o.pc !== 6) $display("FAIL repeat_count got=%0d exp=6", o.pc); else n_pass++;
    n_total++; if (o.p2 !== LAT_IDX + RDELAY) $display("FAIL repeat_delay got=%0d exp=%0d", o.p2, LAT_IDX + RDELAY); else n_pass++;
    n_total++; if (o.p3 !== LAT_IDX + RDELAY + RPERIOD)
      $display("FAIL repeat_period got=%0d exp=%0d", o.p3, LAT_IDX + RDELAY + RPERIOD); else n_pass++;
`else
    n_total++; if (o.pc !== 1) $display("FAIL hold_single_press got=%0d exp=1", o.pc); else n_pass++;
`endif
    n_total++; if (level_o[2] !== 1'b1) $display("FAIL hold_level got=%b exp=1", level_o[2]); else n_pass++;
    @(negedge clk);
    btn_i[2] = 1'b0;
    watch(2, 20, o);
    n_total++; if (o.rc !== 1 || o.pc !== 0)
      $display("FAIL hold_release got=%0d/%0d exp=1/0", o.rc, o.pc); else n_pass++;
  endtask

  initial begin
    reset_i = 1'b1;
    btn_i   = '0;
    test_reset();
    test_press();
    test_release();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_autorepeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
